// File: rtl/sseg_pkg.sv
// Shared segment constants and BCD-to-segment decode for the scan controller.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package sseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  // Non-decimal codes come out blank rather than garbage or X.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Display-side bundle of the scan controller: value load strobe, BCD data,
// leading-zero control in; segment/anode drive and status out.
interface sseg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    blank_lz;
  logic [6:0]              sseg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    update_pending;
  logic                    frame_done;

  modport master (
    output load, bcd_in, blank_lz,
    input  sseg, an, update_pending, frame_done
  );

  modport slave (
    input  load, bcd_in, blank_lz,
    output sseg, an, update_pending, frame_done
  );
endinterface

// File: rtl/sseg_lz_mask.sv
// Leading-zero blank mask: bit i set when digit i and every higher digit are
// zero. Digit 0 is never masked so a zero value still shows a single "0".
module sseg_lz_mask #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] active,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   mask
);

  logic zero_above;

  // Walk from the most significant digit down, tracking "all zero so far".
  always_comb begin
    zero_above = 1'b1;
    mask       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (active[i*4 +: 4] == 4'd0);
      mask[i]    = blank_lz & zero_above & (i != 0);
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// One shared decoder, a per-digit refresh slot with a short dead time, and a
// shadow/active double buffer that only swaps at the frame boundary.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD        = 2
) (
  input  logic            clk,
  input  logic            rst,
  sseg_scan_ctrl_if.slave bus
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("sseg_scan_ctrl: NUM_DIGITS must be 1..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("sseg_scan_ctrl: REFRESH_DIV must be >= 2");
  end
  if (DEAD < 0 || DEAD > REFRESH_DIV - 1) begin : g_bad_dead
    $error("sseg_scan_ctrl: DEAD must be 0..REFRESH_DIV-1");
  end

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BCD_W-1:0]      shadow_q, shadow_d;
  logic [BCD_W-1:0]      active_q, active_d;
  logic                  pend_q, pend_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            sseg_q, sseg_d;

  logic                  div_wrap;
  logic                  fb;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [3:0]            cur_digit;
  logic                  cur_blank;

  sseg_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz_mask (
    .active   (active_q),
    .blank_lz (bus.blank_lz),
    .mask     (lz_mask)
  );

  assign div_wrap = (div_cnt_q == DIV_LAST);
  assign fb       = div_wrap && (idx_q == IDX_LAST);

  // Slot divider and digit index; index steps once per completed slot.
  always_comb begin
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (div_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Double buffer: loads park in shadow, the frame boundary publishes them.
  // A load coinciding with the boundary goes straight to active.
  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    pend_d       = pend_q;
    frame_done_d = fb;
    if (fb) begin
      if (bus.load) begin
        active_d = bus.bcd_in;
        shadow_d = bus.bcd_in;
      end else if (pend_q) begin
        active_d = shadow_q;
      end
      pend_d = 1'b0;
    end else if (bus.load) begin
      shadow_d = bus.bcd_in;
      pend_d   = 1'b1;
    end
  end

  // Next anode/segment drive for the current slot; dark during dead time.
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    an_d      = '1;
    sseg_d    = SEG_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = active_q[i*4 +: 4];
        cur_blank = lz_mask[i];
      end
    end
    if (int'(div_cnt_q) >= DEAD) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx_q != IDX_W'(i));
      end
      sseg_d = cur_blank ? SEG_BLANK : bcd_to_seg(cur_digit);
    end
  end

  // State and output registers; reset leaves the display dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      sseg_q       <= SEG_BLANK;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
    end
  end

  assign bus.sseg           = sseg_q;
  assign bus.an             = an_q;
  assign bus.update_pending = pend_q;
  assign bus.frame_done     = frame_done_q;

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
- Shares one BCD-to-segment decoder across all digits by stepping a digit index at a fixed refresh rate.
- Double-buffers the displayed value so that updates land only on frame boundaries, which prevents tearing.
- Sits between the reaction-timer counter/BCD datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (legal 1..8)
- REFRESH_DIV, 50000, clk cycles per digit slot (legal >= 2)
- DEAD, 2, cycles at the start of each slot with all anodes off, for anti-ghosting (legal 0..REFRESH_DIV-1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  one-cycle strobe; captures bcd_in into the shadow register
- bcd_in  in  4*NUM_DIGITS  packed BCD digits; digit 0 (LSD) is bits [3:0]
- blank_lz  in  1  1 = suppress leading zeros; sampled every cycle
- sseg  out  7  segment drive, active-low, {g,f,e,d,c,b,a}
- an  out  NUM_DIGITS  anode enables, active-low; an[i] selects digit i
- update_pending  out  1  shadow loaded but not yet transferred to active
- frame_done  out  1  one-cycle pulse when the digit index wraps to 0

Behaviour:
- Reset (async, immediate, also mid-frame): div_cnt=0, idx=0, shadow=0, active=0, update_pending=0, frame_done=0, an=all 1s, sseg=7'h7F.
- div_cnt counts 0..REFRESH_DIV-1 and then wraps.
  - On wrap, idx increments and wraps from NUM_DIGITS-1 to 0.
- Frame boundary (FB) = the cycle with idx==NUM_DIGITS-1 and div_cnt==REFRESH_DIV-1.
- Load and transfer:
  - load with no FB in the same cycle: shadow<=bcd_in, update_pending<=1. A later load overwrites shadow; last value wins.
  - At FB with update_pending=1: active<=shadow, update_pending<=0.
  - At FB with load in the same cycle: active<=bcd_in directly, shadow<=bcd_in, update_pending<=0.
- frame_done is registered and asserts for the single cycle after FB.
- Output latency: an and sseg are registered. The state (idx=i, div_cnt=c) sampled at one edge appears on the outputs after the next edge.
- Output rules for the slot state (i, c):
  - c < DEAD: an=all 1s, sseg=7'h7F.
  - Otherwise: an = all 1s except bit i = 0; sseg = decode(active digit i).
- Decoder mapping:
  - Digits 0..9 map as: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes 10..15 give sseg=7'h7F (blank), never X.
- Leading-zero blank:
  - Applies only when blank_lz=1.
  - Digit i is blanked (sseg=7'h7F, anode still driven) if active digit i and every higher digit are 0.
  - Digit 0 is never blanked, so the value 0 shows as a single "0".
- NUM_DIGITS=1: idx stays 0; FB is every div_cnt wrap.
- Width rules:
  - div_cnt width = $clog2(REFRESH_DIV).
  - idx width = max(1, $clog2(NUM_DIGITS)).
  - No arithmetic is performed on BCD values.
- Parameter checks: elaboration-time assertion on all legal ranges.

Decomposition:
- Shared package sseg_pkg holds:
  - SEG_BLANK = 7'h7F
  - the ten digit segment constants
  - a function bcd_to_seg(logic [3:0]) returning 7'h7F for codes >9
- Natural sub-module: sseg_lz_mask.
  - Combinational; takes active and blank_lz.
  - Returns a NUM_DIGITS-bit blank mask.
- The scan counter, double buffer and output registers stay in the top block.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, DEAD=1):
- Reset release, no load -> an cycles 1110,1101,1011,0111, each held 7 cycles after 1 dead cycle (an=1111); sseg=1000000 on every digit; frame_done pulses every 32 cycles.
- load with bcd_in=16'h1234 mid-frame -> update_pending=1; display unchanged until FB; from the next frame digit0 sseg=0011001 (4) and digit3 sseg=1111001 (1); update_pending=0.
- blank_lz=1 with active=16'h0070 -> digits 3 and 2 sseg=7F, digit1=1111000, digit0=1000000; with active=16'h0000 only digit0 shows 1000000.
- load exactly on the FB cycle with 16'h9999, after an earlier pending 16'h5555 -> 9999 displayed next frame; 5555 is never displayed.
- active digit 4'hB -> that slot shows sseg=7F, never X; its anode is still driven low.
- rst asserted while idx=2, div_cnt=5 -> same cycle: an=1111, sseg=7F, update_pending=0; after release, the scan restarts at digit 0, dead cycle first.
